// File: rtl/mmd_event_packer.sv
// mmd_event_packer
//   Multi-channel event packer. Each of NCH detector channels owns a
//   one-entry holding register and a pending flag. A round-robin arbiter
//   moves at most one pending event per clock into a 2**ADDRSIZE x 32-bit
//   FIFO as a record {channel[3:0], sequence[11:0], payload[15:0]}.
//   Readout is block-throttled for a BT pipe: g_ready rises once a full
//   block is stored, or whenever data is present while g_flush is high.
//
// Ports
//   g_clk, g_rst   clock, synchronous active-high reset
//   g_enable       accept events when 1
//   g_flush        allow g_ready on any non-empty FIFO (tail drain)
//   g_valid/g_data per-channel event strobe and payload
//   g_rd_en        pop one word (ignored while empty)
//   g_rd_dout      popped record, valid after the popping edge
//   g_rd_count     words stored
//   g_ready        pipe ready, registered from g_rd_count
//   g_full/g_empty FIFO status
//   g_drop_count   saturating count of lost events
//   g_overflow     sticky flag, set on the first lost event
module mmd_event_packer #(
  parameter int NCH         = 2,
  parameter int DATASIZE    = 8,
  parameter int ADDRSIZE    = 10,
  parameter int COUNTSIZE   = 32,
  parameter int BLOCK_WORDS = 256
) (
  input  logic                    g_clk,
  input  logic                    g_rst,
  input  logic                    g_enable,
  input  logic                    g_flush,
  input  logic [NCH-1:0]          g_valid,
  input  logic [NCH*DATASIZE-1:0] g_data,
  input  logic                    g_rd_en,
  output logic [31:0]             g_rd_dout,
  output logic [ADDRSIZE:0]       g_rd_count,
  output logic                    g_ready,
  output logic                    g_full,
  output logic                    g_empty,
  output logic [COUNTSIZE-1:0]    g_drop_count,
  output logic                    g_overflow
);

  localparam int DEPTH = 1 << ADDRSIZE;
  localparam int IDXW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int DROPW = $clog2(NCH + 1);

  logic [DATASIZE-1:0]  hold [NCH];
  logic [NCH-1:0]       pending;
  logic [IDXW-1:0]      last_grant;
  logic [11:0]          seq;
  logic [31:0]          mem [DEPTH];
  logic [ADDRSIZE:0]    wr_ptr;
  logic [ADDRSIZE:0]    rd_ptr;
  logic [ADDRSIZE:0]    count;
  logic                 full;
  logic                 empty;
  logic                 rd_fire;

  logic                 grant_valid;
  logic [IDXW-1:0]      grant_idx;
  logic [IDXW:0]        cand;
  logic [NCH-1:0]       granted;
  logic [NCH-1:0]       drop_vec;
  logic [DROPW-1:0]     num_drops;
  logic [COUNTSIZE:0]   drop_sum;
  logic [31:0]          wr_record;

  // Occupancy comes from the extra-bit pointers; status is therefore a
  // pure function of registered state.
  assign count      = wr_ptr - rd_ptr;
  assign full       = (count == (ADDRSIZE+1)'(DEPTH));
  assign empty      = (count == {(ADDRSIZE+1){1'b0}});
  assign rd_fire    = g_rd_en & ~empty;
  assign g_rd_count = count;
  assign g_full     = full;
  assign g_empty    = empty;

  // Round-robin arbiter: scan offsets NCH..1 so the smallest offset from
  // last_grant is the one left standing.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = {IDXW{1'b0}};
    cand        = {(IDXW+1){1'b0}};
    for (int k = NCH; k >= 1; k--) begin
      cand = {1'b0, last_grant} + (IDXW+1)'(k);
      if (cand >= (IDXW+1)'(NCH)) begin
        cand = cand - (IDXW+1)'(NCH);
      end else begin
        cand = cand;
      end
      if (pending[cand[IDXW-1:0]] && !full) begin
        grant_valid = 1'b1;
        grant_idx   = cand[IDXW-1:0];
      end else begin
        grant_valid = grant_valid;
      end
    end
  end

  // Per-channel grant/drop decode and the total number dropped this edge.
  always_comb begin
    granted   = {NCH{1'b0}};
    drop_vec  = {NCH{1'b0}};
    num_drops = {DROPW{1'b0}};
    for (int i = 0; i < NCH; i++) begin
      granted[i]  = grant_valid && (grant_idx == IDXW'(i));
      // A channel granted on this edge frees its slot, so a new event reloads it.
      drop_vec[i] = g_enable && g_valid[i] && pending[i] && !granted[i];
      num_drops   = num_drops + DROPW'(drop_vec[i]);
    end
    drop_sum = {1'b0, g_drop_count} + (COUNTSIZE+1)'(num_drops);
  end

  assign wr_record = {4'(grant_idx), seq, 16'(hold[grant_idx])};

  // Holding registers and pending flags.
  always_ff @(posedge g_clk) begin
    if (g_rst) begin
      pending <= {NCH{1'b0}};
      for (int i = 0; i < NCH; i++) begin
        hold[i] <= {DATASIZE{1'b0}};
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (g_enable && g_valid[i] && !drop_vec[i]) begin
          hold[i]    <= g_data[i*DATASIZE +: DATASIZE];
          pending[i] <= 1'b1;
        end else if (granted[i]) begin
          pending[i] <= 1'b0;
        end else begin
          pending[i] <= pending[i];
        end
      end
    end
  end

  // Write side: arbiter pointer, sequence number, write pointer.
  always_ff @(posedge g_clk) begin
    if (g_rst) begin
      last_grant <= IDXW'(NCH - 1);
      seq        <= 12'd0;
      wr_ptr     <= {(ADDRSIZE+1){1'b0}};
    end else if (grant_valid) begin
      last_grant <= grant_idx;
      seq        <= seq + 12'd1;
      wr_ptr     <= wr_ptr + {{ADDRSIZE{1'b0}}, 1'b1};
    end else begin
      last_grant <= last_grant;
      seq        <= seq;
      wr_ptr     <= wr_ptr;
    end
  end

  // RAM array has no reset so it maps onto block memory; pointers discard contents.
  always_ff @(posedge g_clk) begin
    if (grant_valid && !g_rst) begin
      mem[wr_ptr[ADDRSIZE-1:0]] <= wr_record;
    end
  end

  // Read side: registered read data and read pointer.
  always_ff @(posedge g_clk) begin
    if (g_rst) begin
      g_rd_dout <= 32'd0;
      rd_ptr    <= {(ADDRSIZE+1){1'b0}};
    end else if (rd_fire) begin
      g_rd_dout <= mem[rd_ptr[ADDRSIZE-1:0]];
      rd_ptr    <= rd_ptr + {{ADDRSIZE{1'b0}}, 1'b1};
    end else begin
      g_rd_dout <= g_rd_dout;
      rd_ptr    <= rd_ptr;
    end
  end

  // Saturating drop counter and sticky overflow flag.
  always_ff @(posedge g_clk) begin
    if (g_rst) begin
      g_drop_count <= {COUNTSIZE{1'b0}};
      g_overflow   <= 1'b0;
    end else begin
      g_drop_count <= drop_sum[COUNTSIZE] ? {COUNTSIZE{1'b1}} : drop_sum[COUNTSIZE-1:0];
      g_overflow   <= g_overflow | (|drop_vec);
    end
  end

  // Pipe ready trails the occupancy by one edge.
  always_ff @(posedge g_clk) begin
    if (g_rst) begin
      g_ready <= 1'b0;
    end else begin
      g_ready <= (count >= (ADDRSIZE+1)'(BLOCK_WORDS)) || (g_flush && !empty);
    end
  end

endmodule
